// File: rtl/qoi_buffer_ctrl_if.sv
// Control/status and codec handshake bundle between the CPU, memory unit and codec.
// Master drives commands and codec status; slave (the controller) drives sel/start/irq/status.
interface qoi_buffer_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             ctrl_we;
  logic [7:0]       ctrl_wdata;
  logic             fill_flag;
  logic             core_done;
  logic             sel;
  logic             core_start;
  logic             irq;
  logic [7:0]       status;
  logic [CNT_W-1:0] blk_cnt;

  modport master (
    output ctrl_we, ctrl_wdata, fill_flag, core_done,
    input  sel, core_start, irq, status, blk_cnt
  );

  modport slave (
    input  ctrl_we, ctrl_wdata, fill_flag, core_done,
    output sel, core_start, irq, status, blk_cnt
  );
endinterface

// File: rtl/qoi_buffer_ctrl.sv
// Ping-pong buffer sequencer: hands buffers CPU->codec->CPU, starts the codec, watchdogs done, raises IRQ.
// Latency: GO at N -> sel at N+1, core_start at N+2; core_done at M -> sel=0/irq at M+2.
// No backpressure: commands outside their state are dropped. QOI_BUF_CTRL_AUTOSTART_EN lets fill_flag act as GO.
module qoi_buffer_ctrl #(
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  qoi_buffer_ctrl_if.slave         bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_START,
    S_RUN,
    S_RETURN,
    S_WAIT_ACK
  } state_t;

  typedef enum logic [1:0] {
    END_ABORT,
    END_DONE,
    END_TIMEOUT
  } end_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  end_t             end_q, end_d;
  logic [15:0]      wd_q;
  logic             sel_q, busy_q, start_q, irq_q, done_q, terr_q;
  logic             done_d, terr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic go_cmd, ack_cmd, abort_cmd, start_req, wd_expired;

  assign go_cmd    = bus.ctrl_we & bus.ctrl_wdata[0];
  assign ack_cmd   = bus.ctrl_we & bus.ctrl_wdata[1];
  assign abort_cmd = bus.ctrl_we & bus.ctrl_wdata[7];

`ifdef QOI_BUF_CTRL_AUTOSTART_EN
  assign start_req = go_cmd | bus.fill_flag;
  logic unused_bits;
  assign unused_bits = ^bus.ctrl_wdata[6:2];
`else
  assign start_req = go_cmd;
  logic unused_bits;
  assign unused_bits = (^bus.ctrl_wdata[6:2]) ^ bus.fill_flag;
`endif

  assign wd_expired = (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    end_d   = end_q;
    done_d  = done_q;
    terr_d  = terr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (start_req) state_d = S_SWAP;
      S_SWAP:   state_d = S_START;
      S_START:  state_d = S_RUN;
      S_RUN: begin
        // done outranks a same-cycle watchdog expiry
        if (bus.core_done) begin
          state_d = S_RETURN;
          end_d   = END_DONE;
        end else if (wd_expired) begin
          state_d = S_RETURN;
          end_d   = END_TIMEOUT;
        end else if (abort_cmd) begin
          state_d = S_RETURN;
          end_d   = END_ABORT;
        end
      end
      S_RETURN: begin
        state_d = S_WAIT_ACK;
        if (end_q == END_DONE) begin
          done_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end else if (end_q == END_TIMEOUT) begin
          terr_d = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (ack_cmd) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          terr_d  = 1'b0;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      end_q   <= END_ABORT;
      wd_q    <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      irq_q   <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      end_q   <= end_d;
      wd_q    <= (state_q == S_RUN) ? wd_q + 16'd1 : 16'd0;
      // Outputs are registered from the next state so they line up with the state they describe
      sel_q   <= (state_d == S_SWAP) || (state_d == S_START) ||
                 (state_d == S_RUN)  || (state_d == S_RETURN);
      busy_q  <= (state_d == S_SWAP) || (state_d == S_START) ||
                 (state_d == S_RUN)  || (state_d == S_RETURN);
      start_q <= (state_d == S_START);
      irq_q   <= (state_d == S_WAIT_ACK) && (done_d || terr_d);
      done_q  <= done_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.core_start = start_q;
  assign bus.irq        = irq_q;
  assign bus.blk_cnt    = cnt_q;
  assign bus.status     = {5'(cnt_q), terr_q, done_q, busy_q};

endmodule

// File: tb/tb_qoi_buffer_ctrl.sv
// Bench for qoi_buffer_ctrl: scripted opening then random commands/done/reset, checked every cycle
// against a timeline model (block begins at GO cycle g, ends at event cycle e, CPU regains buffers at e+2).
module tb_qoi_buffer_ctrl;
  localparam int TO     = 16;
  localparam int CW     = 2;
  localparam int N_CYC  = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qoi_buffer_ctrl_if #(.CNT_W(CW)) bus ();
  qoi_buffer_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // model: mode 0=CPU idle, 1=block in flight, 2=waiting for ack
  int mode = 0, g = 0, e = -1, outc = 0, ack_c = -1, cnt = 0;
  int m_done = 0, m_terr = 0;

  task automatic model_enter(input int c);
    if (mode == 1 && e >= 0 && c == e + 2) begin
      mode  = 2;
      ack_c = -1;
      if (outc == 1) begin
        m_done = 1;
        cnt++;
      end else if (outc == 2) begin
        m_terr = 1;
      end
    end
    if (mode == 2 && ack_c >= 0 && c == ack_c + 1) begin
      mode   = 0;
      m_done = 0;
      m_terr = 0;
    end
  endtask

  task automatic model_check(input int c);
    int busy, cm;
    busy = (mode == 1) ? 1 : 0;
    cm   = cnt % (1 << CW);
    check_eq("sel",        32'(bus.sel),        32'(busy));
    check_eq("core_start", 32'(bus.core_start), 32'((busy == 1 && c == g + 2) ? 1 : 0));
    check_eq("irq",        32'(bus.irq),        32'((mode == 2 && (m_done + m_terr) > 0) ? 1 : 0));
    check_eq("blk_cnt",    32'(bus.blk_cnt),    32'(cm));
    check_eq("status",     32'(bus.status),     32'((cm % 32) * 8 + m_terr * 4 + m_done * 2 + busy));
  endtask

  task automatic model_update(input int c, input logic r, input logic we, input logic [7:0] wd,
                              input logic ff, input logic dn);
    logic go;
    if (r) begin
      mode = 0; cnt = 0; m_done = 0; m_terr = 0; e = -1; ack_c = -1;
      return;
    end
    go = we && wd[0];
`ifdef QOI_BUF_CTRL_AUTOSTART_EN
    go = go || ff;
`endif
    case (mode)
      0: if (go) begin
        mode = 1; g = c; e = -1;
      end
      1: if (e < 0 && c >= g + 3) begin
        if (dn) begin
          e = c; outc = 1;
        end else if (c - (g + 3) == TO - 1) begin
          e = c; outc = 2;
        end else if (we && wd[7]) begin
          e = c; outc = 3;
        end
      end
      default: if (ack_c < 0 && we && wd[1]) ack_c = c;
    endcase
  endtask

  initial begin
    logic       r, we, ff, dn;
    logic [7:0] wd;
    rst = 1'b1;
    bus.ctrl_we    = 1'b0;
    bus.ctrl_wdata = 8'h00;
    bus.fill_flag  = 1'b0;
    bus.core_done  = 1'b0;
    for (int c = 0; c < N_CYC; c++) begin
      @(negedge clk);
      cyc = c;
      model_enter(c);
      model_check(c);
      r = 1'b0; we = 1'b0; wd = 8'h00; ff = 1'b0; dn = 1'b0;
      if (c < 90) begin
        r = (c < 2);
        case (c)
          5, 30, 55, 60: begin we = 1'b1; wd = 8'h01; end
          26, 66, 80:    begin we = 1'b1; wd = 8'h02; end
          52:            begin we = 1'b1; wd = 8'h03; end
          62:            begin we = 1'b1; wd = 8'h80; end
          default: ;
        endcase
        dn = (c == 20) || (c == 54);
        ff = (c == 70);
      end else begin
        r  = ($urandom_range(0, 599) == 0);
        we = ($urandom_range(0, 3) == 0);
        wd = 8'($urandom);
        if ($urandom_range(0, 3) != 0) wd[7] = 1'b0;
        ff = ($urandom_range(0, 19) == 0);
        dn = (c < 2000) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 59) == 0);
      end
      rst            = r;
      bus.ctrl_we    = we;
      bus.ctrl_wdata = wd;
      bus.fill_flag  = ff;
      bus.core_done  = dn;
      model_update(c, r, we, wd, ff, dn);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
